// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
// Holds FSM state enum, default widths and requester indices.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RDCAP  = 2'd3
    } arb_state_e;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 16;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/data_mem_arb_select2.sv
// arb_select2: two-request winner select plus last-grant pointer.
// Ports: req0/req1 requests, take = a grant is issued this cycle,
//        win = index of the winning requester (valid when a req is high).
// Macro ARB_ROUND_ROBIN_EN: round-robin with registered pointer;
// when undefined, fixed priority (requester 0 wins) and no clk/rst_n.
module arb_select2
    import data_mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst_n,
    input  logic take,
`endif
    input  logic req0,
    input  logic req1,
    output logic win
);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;
    logic last_d;

    always_comb begin
        win = REQ_CPU;
        if (req0 && req1) begin
            // Whoever was not granted last wins the tie.
            win = ~last_q;
        end else if (req1) begin
            win = REQ_DBG;
        end
    end

    always_comb begin
        last_d = last_q;
        if (take) begin
            last_d = win;
        end
    end

    // Reset as "last granted 1" so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_DBG;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        win = REQ_CPU;
        if (!req0 && req1) begin
            win = REQ_DBG;
        end
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the 32x16 sync data memory between the
// LSU (req0) and the debug/DMA loader (req1), one access at a time.
// Ports: req/we/addr/wdata per requester in; gnt/rvalid/rdata out;
//        mem_addr/mem_d_in/mem_wr to memory, mem_d_out from memory.
// Macro ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_d_in,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_d_out
);

    arb_state_e    state_q, state_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_d_in_q, mem_d_in_d;
    logic          mem_wr_q, mem_wr_d;
    logic          owner_q, owner_d;

    logic win;
    logic take;

    // Requests are only sampled in IDLE; others simply wait.
    assign take = (state_q == IDLE) && (req0 || req1);

    arb_select2 u_sel (
`ifdef ARB_ROUND_ROBIN_EN
        .clk   (clk),
        .rst_n (rst_n),
        .take  (take),
`endif
        .req0  (req0),
        .req1  (req1),
        .win   (win)
    );

    always_comb begin
        state_d    = state_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        mem_addr_d = mem_addr_q;
        mem_d_in_d = mem_d_in_q;
        mem_wr_d   = 1'b0;
        owner_d    = owner_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    owner_d = win;
                    if (win == REQ_DBG) begin
                        gnt1_d     = 1'b1;
                        mem_addr_d = addr1;
                        mem_d_in_d = wdata1;
                        mem_wr_d   = we1;
                    end else begin
                        gnt0_d     = 1'b1;
                        mem_addr_d = addr0;
                        mem_d_in_d = wdata0;
                        mem_wr_d   = we0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // mem_wr_q doubles as the command type here.
                state_d = mem_wr_q ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                if (owner_q == REQ_DBG) begin
                    rvalid1_d = 1'b1;
                    rdata1_d  = mem_d_out;
                end else begin
                    rvalid0_d = 1'b1;
                    rdata0_d  = mem_d_out;
                end
                state_d = RDCAP;
            end
            RDCAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            mem_addr_q <= '0;
            mem_d_in_q <= '0;
            mem_wr_q   <= 1'b0;
            owner_q    <= REQ_CPU;
        end else begin
            state_q    <= state_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            mem_addr_q <= mem_addr_d;
            mem_d_in_q <= mem_d_in_d;
            mem_wr_q   <= mem_wr_d;
            owner_q    <= owner_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign mem_addr = mem_addr_q;
    assign mem_d_in = mem_d_in_q;
    assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a 32x16 sync memory.
// Table-driven accesses plus idle, contention and reset sequences.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [4:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [4:0]  mem_addr;
    logic [15:0] mem_d_in;
    logic        mem_wr;
    logic [15:0] mem_d_out = '0;

    logic [15:0] mem [32] = '{0: 16'h0006, 1: 16'h0005, default: 16'h0000};

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_rd0 = '0;
    logic [15:0] exp_rd1 = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_d_in;
        mem_d_out <= mem[mem_addr];
    end

    data_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_addr  (mem_addr),
        .mem_d_in  (mem_d_in),
        .mem_wr    (mem_wr),
        .mem_d_out (mem_d_out)
    );

    typedef struct {
        bit          r;
        bit          w;
        logic [4:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic access(input bit r, input bit w, input logic [4:0] a,
                          input logic [15:0] d, input logic [15:0] exp);
        @(negedge clk);
        if (r) begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end
        @(negedge clk);
        chk("gnt", {30'd0, gnt1, gnt0}, r ? 32'd2 : 32'd1);
        chk("cmd", {mem_wr, mem_addr, mem_d_in}, {w, a, d});
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        if (w) begin
            chk("wr_done", {30'd0, mem_wr, gnt0 | gnt1}, 32'd0);
        end else begin
            chk("rv_early", {30'd0, rvalid1, rvalid0}, 32'd0);
            @(negedge clk);
            if (r) exp_rd1 = exp;
            else exp_rd0 = exp;
            chk("rvalid", {30'd0, rvalid1, rvalid0}, r ? 32'd2 : 32'd1);
            chk("rdata0", {16'd0, rdata0}, {16'd0, exp_rd0});
            chk("rdata1", {16'd0, rdata1}, {16'd0, exp_rd1});
            @(negedge clk);
            chk("rv_pulse", {30'd0, rvalid1, rvalid0}, 32'd0);
        end
    endtask

    initial begin
        int got;
        int rv_seen;
        logic exp_w;

        vecs[0] = '{0, 1, 5'd2,  16'h00AB, 16'h0000};
        vecs[1] = '{0, 0, 5'd2,  16'h0000, 16'h00AB};
        vecs[2] = '{1, 0, 5'd0,  16'h0000, 16'h0006};
        vecs[3] = '{1, 0, 5'd1,  16'h0000, 16'h0005};
        vecs[4] = '{0, 1, 5'd31, 16'hBEEF, 16'h0000};
        vecs[5] = '{0, 0, 5'd31, 16'h0000, 16'hBEEF};
        vecs[6] = '{0, 0, 5'd0,  16'h0000, 16'h0006};
        vecs[7] = '{1, 1, 5'd7,  16'h1234, 16'h0000};
        vecs[8] = '{0, 0, 5'd7,  16'h0000, 16'h1234};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rdata", {rdata1, rdata0}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle", {22'd0, mem_wr, mem_addr, gnt0, gnt1,
                         rvalid0, rvalid1}, 32'd0);
        end

        for (int i = 0; i < 9; i++) begin
            access(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp);
        end

        // Reset pulsed while a read sits in ISSUE.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd2;
        @(negedge clk);
        chk("pre_rst_gnt", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {22'd0, mem_wr, mem_addr, gnt0, gnt1,
                          rvalid0, rvalid1}, 32'd0);
        chk("rst_rd", {rdata1, rdata0}, 32'd0);
        exp_rd0 = '0;
        exp_rd1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        rv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalid0 || rvalid1) rv_seen++;
        end
        chk("rst_no_rv", rv_seen, 0);
        access(1'b1, 1'b0, 5'd1, 16'h0000, 16'h0005);

        // Both requesters held continuously with writes.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd10; wdata0 = 16'h0A0A;
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'd11; wdata1 = 16'h0B0B;
        got = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_w = got[0];
`else
                exp_w = 1'b0;
`endif
                chk("cont_gnt", {30'd0, gnt1, gnt0},
                    exp_w ? 32'd2 : 32'd1);
                got++;
            end
        end
        chk("cont_count", got, 4);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("loc0_intact", {16'd0, mem[0]}, 32'h0006);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and sequencer for the 32 x 16-bit synchronous data memory. It shares the memory between requester 0 (processor load/store unit) and requester 1 (debug/DMA loader). It accepts one access at a time and drives the memory's address, write-data and write-enable from registers. For reads, it captures the memory's registered read data and returns it to the owning requester with a one-cycle valid strobe.

## Interface
Parameters:
- AW, 5: address width, matches the memory's address port.
- DW, 16: data width, matches the memory's data ports.

Ports:
- clk  in  1  single clock, rising edge; the same clk drives the data memory.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request, held until the matching gnt.
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  in  AW  word address; stable while req is high.
- wdata0 / wdata1  in  DW  write data; stable while req is high.
- gnt0 / gnt1  out  1  one-cycle pulse: the request has been accepted.
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata is valid for that requester.
- rdata0 / rdata1  out  DW  read data, held until the next rvalid to the same port.
- mem_addr  out  AW  to memory address port.
- mem_d_in  out  DW  to memory write-data port.
- mem_wr  out  1  to memory write enable.
- mem_d_out  in  DW  from memory registered read-data port.

## Operation
- The FSM has four states: IDLE, ISSUE, RDWAIT, RDCAP.
- IDLE:
  - If any req is high, select a winner, register its addr/wdata/we onto mem_addr/mem_d_in/mem_wr, pulse its gnt, and go to ISSUE.
  - With no request, mem_wr stays 0.
- ISSUE (command on memory pins across one clk edge):
  - Write: the memory stores at this edge. Next state: mem_wr <= 0, go to IDLE.
  - Read: the memory loads mem_d_out at this edge. Go to RDWAIT.
- RDWAIT: capture mem_d_out into the owner's rdata and pulse its rvalid. Go to RDCAP.
- RDCAP: one turnaround cycle, then go to IDLE.
- Arbitration with the round-robin build:
  - A last-grant pointer is updated on every grant.
  - On simultaneous requests, the requester not granted last wins.
  - A single request always wins immediately.
- mem_wr is high only in ISSUE for a write. The memory is never driven with an undefined mem_wr.
- A new request is sampled only in IDLE. Requests arriving in other states wait; they are never dropped.
- The address is used as-is. There is no wrap or range check, and all 32 locations are legal.

## Timing
- All outputs come from registers. There is no combinational path from inputs to outputs.
- Reset values: state = IDLE, gnt0/1 = 0, rvalid0/1 = 0, rdata0/1 = 0, mem_addr = 0, mem_d_in = 0, mem_wr = 0, pointer = "last granted 1" so requester 0 wins first.
- Write: req sampled at edge N; gnt and command visible in cycle N+1; memory writes at edge N+2; arbiter is back in IDLE after N+2; the next grant can appear in cycle N+3.
- Read: gnt in N+1; memory read at edge N+2; rvalid/rdata visible in cycle N+3; arbiter re-enters IDLE after N+4.
- Requester side:
  - Deassert req (or present a new command) in the cycle after observing gnt.
  - A req still high after gnt is treated as a new request.
- Reset asserted mid-operation: all outputs go immediately to their reset values.
  - A write whose edge had not yet occurred is lost.
  - A read in flight returns no rvalid.

## Configuration
- ARB_ROUND_ROBIN_EN defined: two-way round-robin as described; the pointer register is present.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins on contention. The pointer register is removed, and requester 1 may starve under continuous req0.

## Structure
- Shared package data_mem_arb_pkg holds:
  - the FSM state enum (IDLE, ISSUE, RDWAIT, RDCAP);
  - the AW/DW default constants (5, 16);
  - the requester-index constants (REQ_CPU = 0, REQ_DBG = 1).
- Sub-module arb_select2: combinational two-request winner select plus the registered last-grant pointer. It contains the ARB_ROUND_ROBIN_EN conditional.
- The top level holds the FSM, the command registers and the per-port rdata registers.

## Test plan
- After reset release with no req: mem_wr=0, mem_addr=0, all gnt/rvalid=0 for 10 cycles.
- req0 write addr 2, data 16'h00AB, then req0 read addr 2: gnt0 one cycle after req; rvalid0 with rdata0=16'h00AB three cycles after the read req.
- Preloaded locations: req1 read addr 0 -> rdata1=16'h0006; req1 read addr 1 -> rdata1=16'h0005; rvalid0 stays 0.
- req0 and req1 both held continuously:
  - with ARB_ROUND_ROBIN_EN, grants alternate 0,1,0,1;
  - without it, only gnt0 fires.
- req0 write addr 31 (wrap boundary), then read addr 31 and addr 0: returns written data and 16'h0006 respectively. Location 0 is not corrupted.
- rst_n pulsed low in ISSUE of a read: no rvalid; after release, the next access completes with normal latency.
